// File: rtl/neuron_pe_multilane_if.sv
// Bundle of the neuron's config bus, input beat stream and result stream.
// master = layer-array side driving config and beats, slave = the neuron.
interface neuron_pe_multilane_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16
);
  logic                      weight_valid;
  logic                      bias_valid;
  logic [31:0]               weight_value;
  logic [31:0]               bias_value;
  logic [31:0]               config_layer_num;
  logic [31:0]               config_neuron_num;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output weight_valid, bias_valid, weight_value, bias_value,
    output config_layer_num, config_neuron_num,
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  weight_valid, bias_valid, weight_value, bias_value,
    input  config_layer_num, config_neuron_num,
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/neuron_pe_multilane.sv
// Multi-lane fully-connected neuron: LANES signed MACs per beat against per-lane
// weight RAMs, saturating accumulate, runtime bias, ReLU or saturating linear output.
module neuron_pe_multilane #(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 784,
  parameter int LANES      = 4,
  parameter int DATA_W     = 16,
  parameter int W_INT      = 1,
  parameter int ACT_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  neuron_pe_multilane_if.slave  bus
);

  localparam int BEATS = NUM_WEIGHT / LANES;
  localparam int AW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam int SW    = PW + $clog2(LANES);
  localparam int TW    = SW + 1;
  localparam int FB    = DATA_W - W_INT;
  localparam int FRAC  = PW - 1 - W_INT;

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, BIAS, OUT} state_t;

  state_t                    state_reg, state_next;
  logic                      in_ready_reg;
  logic                      out_valid_reg;
  logic [DATA_W-1:0]         out_data_reg;
  logic signed [PW-1:0]      acc_reg;
  logic signed [DATA_W-1:0]  bias_reg;
  logic [CW-1:0]             beat_cnt_reg;
  logic [AW-1:0]             wbeat_reg;
  logic [LW-1:0]             wlane_reg;
  logic                      s1_valid_reg, s2_valid_reg, s3_valid_reg;

  logic                      id_match;
  logic                      weight_we;
  logic                      bias_we;
  logic                      in_fire;
  logic [AW-1:0]             rd_addr;
  logic [LANES*PW-1:0]       prod_flat;
  logic signed [SW-1:0]      tree_sum;
  logic signed [PW-1:0]      bias_ext;
  logic signed [PW-1:0]      acc_plus_tree;
  logic signed [PW-1:0]      acc_plus_bias;

  // Adds a wide term to the accumulator, clamping to the PW-bit signed range.
  function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                   input logic signed [SW-1:0] b);
    logic signed [TW-1:0] t;
    t = TW'(a) + TW'(b);
    if (t[TW-1:PW-1] == {(TW-PW+1){t[TW-1]}})
      return t[PW-1:0];
    else if (t[TW-1])
      return {1'b1, {(PW-1){1'b0}}};
    else
      return {1'b0, {(PW-1){1'b1}}};
  endfunction

  function automatic logic [DATA_W-1:0] activate(input logic signed [PW-1:0] a);
    logic [DATA_W-1:0] s;
    s = a[FRAC -: DATA_W];
    if (ACT_MODE == 0) begin
      if (a[PW-1])
        return '0;
      else if (|a[PW-2 -: W_INT])
        return {1'b0, {(DATA_W-1){1'b1}}};
      else
        return s;
    end else begin
      if (a[PW-1 -: W_INT+1] == {(W_INT+1){a[PW-1]}})
        return s;
      else if (a[PW-1])
        return {1'b1, {(DATA_W-1){1'b0}}};
      else
        return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  assign id_match  = (bus.config_layer_num == 32'(LAYER_NO)) &&
                     (bus.config_neuron_num == 32'(NEURON_NO));
  assign weight_we = (state_reg == IDLE) && bus.weight_valid && id_match;
  assign bias_we   = (state_reg == IDLE) && bus.bias_valid && id_match;
  assign in_fire   = bus.in_valid && in_ready_reg;
  assign rd_addr   = beat_cnt_reg[AW-1:0];

  // One weight RAM per lane; word i lives in lane i%LANES at address i/LANES.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] ram [BEATS];
      logic signed [DATA_W-1:0] w_reg;
      logic signed [DATA_W-1:0] x_reg;
      logic signed [PW-1:0]     prod_reg;

      always_ff @(posedge clk) begin
        if (weight_we && (wlane_reg == LW'(gi)))
          ram[wbeat_reg] <= bus.weight_value[DATA_W-1:0];
        if (in_fire) begin
          w_reg <= ram[rd_addr];
          x_reg <= bus.in_data[gi*DATA_W +: DATA_W];
        end
        prod_reg <= PW'(w_reg) * PW'(x_reg);
      end

      assign prod_flat[gi*PW +: PW] = prod_reg;
    end

    if (DATA_W < 32) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{bus.weight_value[31:DATA_W], bus.bias_value[31:DATA_W]};
    end
  endgenerate

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++)
      tree_sum = tree_sum + SW'($signed(prod_flat[k*PW +: PW]));
  end

  assign bias_ext      = PW'(bias_reg) <<< FB;
  assign acc_plus_tree = sat_add(acc_reg, tree_sum);
  assign acc_plus_bias = sat_add(acc_reg, SW'(bias_ext));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_fire) state_next = (BEATS == 1) ? DRAIN : ACC;
      ACC:     if (in_fire && (beat_cnt_reg == CW'(BEATS - 1))) state_next = DRAIN;
      DRAIN:   if (!s1_valid_reg && !s2_valid_reg && !s3_valid_reg) state_next = BIAS;
      BIAS:    state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      acc_reg       <= '0;
      bias_reg      <= '0;
      beat_cnt_reg  <= '0;
      wbeat_reg     <= '0;
      wlane_reg     <= '0;
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s3_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == IDLE) || (state_next == ACC);
      out_valid_reg <= (state_next == OUT);
      s1_valid_reg  <= in_fire;
      s2_valid_reg  <= s1_valid_reg;
      s3_valid_reg  <= s2_valid_reg;

      if (weight_we) begin
        if (wlane_reg == LW'(LANES - 1)) begin
          wlane_reg <= '0;
          wbeat_reg <= (wbeat_reg == AW'(BEATS - 1)) ? '0 : wbeat_reg + 1'b1;
        end else begin
          wlane_reg <= wlane_reg + 1'b1;
        end
      end

      if (bias_we)
        bias_reg <= bus.bias_value[DATA_W-1:0];

      if (in_fire)
        beat_cnt_reg <= beat_cnt_reg + 1'b1;

      if (s2_valid_reg)
        acc_reg <= acc_plus_tree;

      if (state_reg == BIAS) begin
        acc_reg      <= acc_plus_bias;
        out_data_reg <= activate(acc_plus_bias);
      end

      if ((state_reg == OUT) && bus.out_ready) begin
        acc_reg      <= '0;
        beat_cnt_reg <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

endmodule
